// File: rtl/array_proc_sched.sv
`default_nettype none
// ============================================================================
// Module      : array_proc_sched
// Description : Round-robin scheduler that merges two sample requesters into
//               one array write port, accumulates frame sum/count and hands
//               each closed frame to a downstream consumer.
// Revision    : 1.0 - initial release
// ============================================================================
module array_proc_sched #(
  parameter int DW    = 8,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_valid,
  input  logic [DW-1:0]    a_data,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [DW-1:0]    b_data,
  output logic             b_ready,
  input  logic             flush,
  output logic             wr_en,
  output logic [AW-1:0]    wr_addr,
  output logic [DW-1:0]    wr_data,
  output logic             out_valid,
  output logic [DW+AW-1:0] out_sum,
  output logic [AW:0]      out_count,
  input  logic             out_ready
);

  typedef enum logic [0:0] {
    FILL = 1'b0,
    DONE = 1'b1
  } state_t;

  localparam logic [AW:0] c_DEPTH = (AW+1)'(DEPTH);

  state_t           r_state;
  logic             r_last_b;
  logic [AW:0]      r_count;
  logic [DW+AW-1:0] r_sum;

  logic             w_grant_a;
  logic             w_grant_b;
  logic             w_xfer;
  logic             w_close;
  logic [DW-1:0]    w_data;
  logic [AW:0]      w_count_inc;

  // On a tie the requester that did not win the last transfer is served.
  assign w_grant_a   = (r_state == FILL) && a_valid && (!b_valid || r_last_b);
  assign w_grant_b   = (r_state == FILL) && b_valid && (!a_valid || !r_last_b);
  assign w_xfer      = w_grant_a || w_grant_b;
  assign w_data      = w_grant_a ? a_data : b_data;
  assign w_count_inc = r_count + 1'b1;
  assign w_close     = (w_xfer && (w_count_inc == c_DEPTH)) ||
                       (flush && ((r_count != '0) || w_xfer));

  assign a_ready   = w_grant_a;
  assign b_ready   = w_grant_b;
  assign out_sum   = r_sum;
  assign out_count = r_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= FILL;
      r_last_b  <= 1'b1;
      r_count   <= '0;
      r_sum     <= '0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      out_valid <= 1'b0;
    end else begin
      wr_en <= w_xfer;
      if (w_xfer) begin
        wr_addr  <= r_count[AW-1:0];
        wr_data  <= w_data;
        r_count  <= w_count_inc;
        r_sum    <= r_sum + {{AW{1'b0}}, w_data};
        r_last_b <= w_grant_b;
      end
      case (r_state)
        FILL: begin
          if (w_close) begin
            r_state   <= DONE;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          // No transfer can occur in DONE, so clearing here never races an update.
          if (out_valid && out_ready) begin
            r_state   <= FILL;
            out_valid <= 1'b0;
            r_count   <= '0;
            r_sum     <= '0;
          end
        end
        default: r_state <= FILL;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/array_proc_sched.md
# array_proc_sched

Round-robin scheduler that shares one array-processing datapath between two requesters. It accepts samples from ports A and B over valid/ready handshakes and sequences writes into the 8-entry sample array. It maintains the running frame sum and frame count, and presents each completed frame (full or flushed) to a downstream consumer. It sits between the sample producers and the array/accumulator datapath and is the only writer of the array.

## Interface
- DW, 8, sample data width
- DEPTH, 8, samples per frame; power of two, ≥2
- AW, 3, array address width, log2(DEPTH)

- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-low reset
- a_valid  in  1  requester A has a sample
- a_data  in  DW  requester A sample
- a_ready  out  1  A sample accepted this cycle when a_valid & a_ready
- b_valid  in  1  requester B has a sample
- b_data  in  DW  requester B sample
- b_ready  out  1  B accept, same rule as A
- flush  in  1  close the current partial frame early
- wr_en  out  1  array write strobe
- wr_addr  out  AW  array write address
- wr_data  out  DW  array write data
- out_valid  out  1  completed frame available
- out_sum  out  DW+AW  frame sum, unsigned, no overflow possible
- out_count  out  AW+1  samples in frame, 1..DEPTH
- out_ready  in  1  consumer takes frame when out_valid & out_ready

## Operation
- Two-state FSM:
  - FILL: accepts samples.
  - DONE: holds frame for the consumer; no samples accepted.
- Grant (combinational, FILL only):
  - Only one valid: that requester is granted.
  - Both valid: the requester not in last_grant is granted.
  - In DONE, a_ready = b_ready = 0.
- last_grant updates only on an actual transfer.
- Requesters keep valid and data stable until accepted. The scheduler never drops a sample whose ready was high.
- On a transfer:
  - Array slot count receives the sample.
  - count increments.
  - sum += zero-extended sample.
- FILL → DONE on the edge where either:
  - the transfer makes count == DEPTH, or
  - flush = 1 and (count > 0 or a transfer occurs that cycle).
- A transfer coincident with flush is included in the frame.
- flush with count == 0 and no transfer: ignored.
- flush in DONE: ignored.
- DONE → FILL on out_valid & out_ready. On that edge, count and sum clear to 0.
- out_sum and out_count are the sum and count registers. They are stable throughout DONE.
- Reset values:
  - State FILL, count 0, sum 0, last_grant = B (so A wins the first tie).
  - wr_en 0, wr_addr 0, wr_data 0.
  - out_valid 0, out_sum 0, out_count 0.
  - a_ready/b_ready follow combinationally from the valids.
- Reset mid-frame discards the partial frame; no frame output.

## Timing
- a_ready/b_ready: combinational from state, a_valid, b_valid and last_grant. No dependence on data or out_ready.
- Write port is registered: wr_en/wr_addr/wr_data assert the cycle after the transfer, for exactly one cycle. wr_addr = count before increment.
- count/sum update on the transfer edge.
- out_valid is a registered decode of DONE. It rises the cycle after the closing transfer or flush, and falls the cycle after the out_ready handshake.
- First accept of the next frame is possible the cycle after the out handshake.
- Throughput: one sample per clock in FILL. Minimum one DONE cycle per frame.
- Sample-to-frame latency: 1 cycle from the closing transfer to out_valid.

## Test plan
- Reset, then A alone streams 0x01..0x08, one per cycle, out_ready=1:
  - a_ready high for 8 cycles.
  - wr_addr 0..7, each one cycle after its accept.
  - out_valid for one cycle with out_sum=36, out_count=8.
- A and B both valid continuously, A data 0x10, B data 0x20:
  - Grants alternate A,B,A,B…
  - Frame sum = 4·0x10 + 4·0x20 = 0xC0, out_count=8.
- All 8 samples 0xFF:
  - out_sum = 0x7F8, no wrap.
  - With out_ready held low for 5 cycles: out_valid held, a_ready=0 throughout, sum stable.
- Three samples (5, 6, 7) then flush on the cycle of a fourth transfer (8):
  - out_count=4, out_sum=26.
  - Flush with count 0 and no valids: no out_valid.
- rst pulsed low after 5 accepts:
  - All outputs return to reset values immediately.
  - Next frame starts at wr_addr 0 with sum 0.
  - A wins the first tie.
